// File: rtl/surf_cmd_receiver.sv
// SURF-side receiver for the serial CMD line from the TURF event generator.
// Deserializes digitize-command frames into an event ID and a buffer number,
// checks parity and framing, and holds the decoded event until readout acks it.
//
// Frame, one bit per clk33_i: start(1), ID (LSB first), buffer (LSB first),
// even-parity bit over ID+buffer+parity, stop(0).
//
// Ports:
//   clk33_i        system clock, one CMD bit per cycle
//   rst_i          synchronous active-high reset
//   CMD_i          serial command line (asynchronous, idles low)
//   evt_ack_i      readout consumed the held event (pulse)
//   evid_o         held event ID
//   buffer_o       held buffer number
//   evt_valid_o    held event present
//   evt_new_o      pulse: new event latched
//   err_parity_o   pulse: parity error, frame dropped
//   err_frame_o    pulse: stop bit was 1, frame dropped
//   err_overrun_o  pulse: good frame dropped because an event is still held
//   parity_cnt_o   saturating parity-error count
//   frame_cnt_o    saturating framing-error count
//   overrun_cnt_o  saturating overrun count
module surf_cmd_receiver #(
  parameter int unsigned ID_BITS  = 32,
  parameter int unsigned BUF_BITS = 2,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                clk33_i,
  input  logic                rst_i,
  input  logic                CMD_i,
  input  logic                evt_ack_i,
  output logic [ID_BITS-1:0]  evid_o,
  output logic [BUF_BITS-1:0] buffer_o,
  output logic                evt_valid_o,
  output logic                evt_new_o,
  output logic                err_parity_o,
  output logic                err_frame_o,
  output logic                err_overrun_o,
  output logic [CNT_BITS-1:0] parity_cnt_o,
  output logic [CNT_BITS-1:0] frame_cnt_o,
  output logic [CNT_BITS-1:0] overrun_cnt_o
);

  localparam int unsigned PayBits = ID_BITS + BUF_BITS;
  localparam int unsigned CntW    = $clog2(PayBits + 1);

  typedef enum logic [2:0] {StIdle, StShift, StParity, StStop, StWaitIdle} state_e;

  state_e state_q, state_d;

  logic               sync1_q, sync2_q, cmd_s;
  logic [CntW-1:0]    bit_cnt_q;
  logic               par_q;
  logic [PayBits-1:0] payload_q;
  logic               stop_good, stop_parity, stop_frame;
  logic               accept, overrun;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer for the asynchronous CMD line.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= CMD_i;
      sync2_q <= sync1_q;
    end
  end

  assign cmd_s = sync2_q;

  // FSM state register.
  always_ff @(posedge clk33_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cmd_s) state_d = StShift;
      StShift:    if (bit_cnt_q == CntW'(PayBits - 1)) state_d = StParity;
      StParity:   state_d = StStop;
      StStop:     state_d = cmd_s ? StWaitIdle : StIdle;
      StWaitIdle: if (!cmd_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs: frame verdict, valid only while the stop bit is on cmd_s.
  always_comb begin
    stop_good   = 1'b0;
    stop_parity = 1'b0;
    stop_frame  = 1'b0;
    if (state_q == StStop) begin
      stop_frame  = cmd_s;
      stop_parity = !cmd_s && par_q;
      stop_good   = !cmd_s && !par_q;
    end
  end

  // Shift/parity datapath. par_q ends up as the XOR of payload and parity bits.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          par_q     <= 1'b0;
        end
        StShift: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          par_q     <= par_q ^ cmd_s;
          // Shift in at the MSB so the first (LSB) bit lands at bit 0.
          payload_q <= {cmd_s, payload_q[PayBits-1:1]};
        end
        StParity: par_q <= par_q ^ cmd_s;
        default: ;
      endcase
    end
  end

  // An ack in the verdict cycle frees the holding register for the new frame.
  assign accept  = stop_good && (!evt_valid_o || evt_ack_i);
  assign overrun = stop_good && evt_valid_o && !evt_ack_i;

  // Event holding register, result pulses and error counters.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      evid_o        <= '0;
      buffer_o      <= '0;
      evt_valid_o   <= 1'b0;
      evt_new_o     <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
      parity_cnt_o  <= '0;
      frame_cnt_o   <= '0;
      overrun_cnt_o <= '0;
    end else begin
      evt_new_o     <= accept;
      err_parity_o  <= stop_parity;
      err_frame_o   <= stop_frame;
      err_overrun_o <= overrun;
      if (accept) begin
        evid_o      <= payload_q[ID_BITS-1:0];
        buffer_o    <= payload_q[PayBits-1:ID_BITS];
        evt_valid_o <= 1'b1;
      end else if (evt_ack_i) begin
        evt_valid_o <= 1'b0;
      end
      if (stop_parity) parity_cnt_o  <= sat_inc(parity_cnt_o);
      if (stop_frame)  frame_cnt_o   <= sat_inc(frame_cnt_o);
      if (overrun)     overrun_cnt_o <= sat_inc(overrun_cnt_o);
    end
  end

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Self-checking bench for surf_cmd_receiver: table of single-frame vectors plus
// hand-written sequences for framing resync, back-to-back frames, reset and
// counter saturation.
module tb_surf_cmd_receiver;

  localparam int FrameLen = 37;

  logic        clk;
  logic        rst;
  logic        cmd;
  logic        ack;
  logic [31:0] evid;
  logic [1:0]  bufn;
  logic        valid, evt_new, perr, ferr, ovr;
  logic [7:0]  par_cnt, frm_cnt, ovr_cnt;

  surf_cmd_receiver #(
    .ID_BITS (32),
    .BUF_BITS(2),
    .CNT_BITS(8)
  ) dut (
    .clk33_i      (clk),
    .rst_i        (rst),
    .CMD_i        (cmd),
    .evt_ack_i    (ack),
    .evid_o       (evid),
    .buffer_o     (bufn),
    .evt_valid_o  (valid),
    .evt_new_o    (evt_new),
    .err_parity_o (perr),
    .err_frame_o  (ferr),
    .err_overrun_o(ovr),
    .parity_cnt_o (par_cnt),
    .frame_cnt_o  (frm_cnt),
    .overrun_cnt_o(ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int stamps[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (evt_new) stamps.push_back(cyc);

  int total = 0;
  int passed = 0;
  int exp_par = 0, exp_frm = 0, exp_ovr = 0;

  typedef struct {
    logic        pre_ack;
    logic [31:0] id;
    logic [1:0]  bufn;
    logic        bad_par;
    logic        ack_latch;
    logic [3:0]  exp_pulse;  // {new, parity, frame, overrun}
    logic        exp_valid;
    logic [31:0] exp_evid;
    logic [1:0]  exp_buf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [FrameLen-1:0] build_frame(input logic [31:0] id, input logic [1:0] b,
                                                      input logic bad_par, input logic stop);
    logic [FrameLen-1:0] f;
    f[0]     = 1'b1;
    f[32:1]  = id;
    f[34:33] = b;
    f[35]    = (^{id, b}) ^ bad_par;
    f[36]    = stop;
    return f;
  endfunction

  // Drives the first n bits of f, one per cycle; returns in the cycle after the last bit.
  task automatic send_bits(input logic [FrameLen-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      cmd = f[i];
      step();
    end
  endtask

  task automatic send_frame(input logic [31:0] id, input logic [1:0] b, input logic bad_par);
    send_bits(build_frame(id, b, bad_par, 1'b0), FrameLen);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  initial begin
    int first_k;
    int nferr;
    int npulse;

    vecs[0] = '{1'b0, 32'h0000_0001, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h0, 2'd0};
    vecs[1] = '{1'b0, 32'h0000_0005, 2'd2, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h5, 2'd2};
    vecs[2] = '{1'b1, 32'h0000_0007, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h7, 2'd0};
    vecs[3] = '{1'b0, 32'h0000_0008, 2'd3, 1'b0, 1'b0, 4'b0001, 1'b1, 32'h7, 2'd0};
    vecs[4] = '{1'b0, 32'h0000_0009, 2'd1, 1'b0, 1'b1, 4'b1000, 1'b1, 32'h9, 2'd1};
    vecs[5] = '{1'b0, 32'hA5A5_0F0F, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h9, 2'd1};

    rst = 1'b1;
    cmd = 1'b0;
    ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_outputs", {evid, bufn, valid, evt_new, perr, ferr, ovr, par_cnt, frm_cnt, ovr_cnt},
          64'd0);

    // Table-driven single frames; stop bit is cycle N, results expected at N+3.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_ack) begin
        pulse_ack();
        check($sformatf("v%0d_pre_ack_valid", v), valid, 1'b0);
      end
      send_frame(vecs[v].id, vecs[v].bufn, vecs[v].bad_par);
      cmd = 1'b0;
      check($sformatf("v%0d_quiet_n1", v), {evt_new, perr, ferr, ovr}, 4'b0);
      step();
      if (vecs[v].ack_latch) ack = 1'b1;
      check($sformatf("v%0d_quiet_n2", v), {evt_new, perr, ferr, ovr}, 4'b0);
      step();
      ack = 1'b0;
      exp_par += int'(vecs[v].exp_pulse[2]);
      exp_ovr += int'(vecs[v].exp_pulse[0]);
      check($sformatf("v%0d_pulses", v), {evt_new, perr, ferr, ovr}, vecs[v].exp_pulse);
      check($sformatf("v%0d_valid", v), valid, vecs[v].exp_valid);
      check($sformatf("v%0d_evid", v), evid, vecs[v].exp_evid);
      check($sformatf("v%0d_buf", v), bufn, vecs[v].exp_buf);
      check($sformatf("v%0d_counts", v), {par_cnt, frm_cnt, ovr_cnt},
            {8'(exp_par), 8'(exp_frm), 8'(exp_ovr)});
      step();
      check($sformatf("v%0d_pulse_end", v), {evt_new, perr, ferr, ovr}, 4'b0);
    end

    // Framing error: stop bit 1, line held high, then low, then a good frame.
    pulse_ack();
    send_bits(build_frame(32'h33, 2'd0, 1'b0, 1'b1), FrameLen);
    first_k = -1;
    nferr = 0;
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) cmd = 1'b0;
      if (ferr) begin
        nferr++;
        if (first_k < 0) first_k = k;
      end
      if (evt_new || perr || ovr) npulse++;
      step();
    end
    exp_frm++;
    check("frame_err_count_pulses", nferr, 1);
    check("frame_err_latency", first_k, 2);
    check("frame_err_no_other", npulse, 0);
    check("frame_cnt", frm_cnt, 8'(exp_frm));
    send_frame(32'hDEAD_BEEF, 2'd1, 1'b0);
    cmd = 1'b0;
    step();
    step();
    check("resync_new", evt_new, 1'b1);
    check("resync_evid", evid, 32'hDEAD_BEEF);
    check("resync_buf", bufn, 2'd1);
    pulse_ack();

    // Back-to-back frames with zero gap, each acked as soon as it lands.
    stamps.delete();
    fork
      begin
        send_frame(32'h10, 2'd0, 1'b0);
        send_frame(32'h11, 2'd0, 1'b0);
        cmd = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int t;
          t = 0;
          while (!evt_new && t < 200) begin
            step();
            t++;
          end
          if (t >= 200) check($sformatf("b2b_wait%0d", k), 1'b0, 1'b1);
          ack = 1'b1;
          step();
          ack = 1'b0;
        end
      end
    join
    check("b2b_pulses", stamps.size(), 2);
    if (stamps.size() == 2) check("b2b_spacing", stamps[1] - stamps[0], 37);
    check("b2b_evid", evid, 32'h11);
    check("b2b_valid_cleared", valid, 1'b0);
    check("b2b_no_overrun", ovr_cnt, 8'(exp_ovr));

    // Reset partway through a third frame.
    send_bits(build_frame(32'h12, 2'd0, 1'b0, 1'b0), 15);
    cmd = 1'b0;
    rst = 1'b1;
    step();
    check("midframe_reset_outputs",
          {evid, bufn, valid, evt_new, perr, ferr, ovr, par_cnt, frm_cnt, ovr_cnt}, 64'd0);
    step();
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 45; k++) begin
      if (evt_new || perr || ferr || ovr || valid) npulse++;
      step();
    end
    check("midframe_reset_no_pulse", npulse, 0);

    // Parity counter saturation.
    for (int i = 0; i < 254; i++) send_frame(32'h1, 2'd0, 1'b1);
    cmd = 1'b0;
    repeat (3) step();
    check("par_cnt_254", par_cnt, 8'd254);
    for (int i = 0; i < 46; i++) send_frame(32'h1, 2'd0, 1'b1);
    cmd = 1'b0;
    repeat (3) step();
    check("par_cnt_sat", par_cnt, 8'd255);
    send_frame(32'h1, 2'd0, 1'b1);
    cmd = 1'b0;
    step();
    step();
    check("par_pulse_at_sat", perr, 1'b1);
    step();
    check("par_cnt_holds", par_cnt, 8'd255);
    check("sat_others_zero", {frm_cnt, ovr_cnt, valid}, 17'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
